hart_request_ctrl: RTL and testbench

Per-hart issue-eligibility tracker for the multithreaded core. It generates the `request` vector consumed by the round-robin thread arbiter and observes the arbiter's grant. It also tracks each hart's in-flight instruction, outstanding data loads and branch/jump redirects, so a hart requests again only when its next instruction may legally enter the pipeline. It sits between the arbiter and the ID/EX/WB stages and the data-memory interface.

---
 rtl/riscv_defines.sv | 22 ++
 rtl/hart_id_fifo.sv | 60 ++++++
 rtl/hart_request_ctrl.sv | 141 ++++++++++++++
 tb/tb_hart_request_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defines.sv
`default_nettype none
// ============================================================================
// Module   : riscv_defines
// Purpose  : Shared core-wide constants and per-hart issue state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_defines;

  localparam int NUM_THREADS       = 4;
  localparam int THREAD_ADDR_WIDTH = $clog2(NUM_THREADS);
  localparam int HART_CNT_WIDTH    = 4;

  typedef enum logic [2:0] {
    HART_OFF      = 3'd0,
    HART_READY    = 3'd1,
    HART_ISSUED   = 3'd2,
    HART_WAIT_LD  = 3'd3,
    HART_REDIRECT = 3'd4
  } hart_state_e;

endpackage
`default_nettype wire

// File: rtl/hart_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : hart_id_fifo
// Purpose  : In-order FIFO of hart indices for returns that complete in order.
// Revision : 1.0 - initial release
// ============================================================================
module hart_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CNT_W    = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == FULL_CNT);
  assign w_do_pop  = pop & ~empty;
  // A push that coincides with a pop on an empty FIFO is consumed in place.
  assign w_do_push = push & (pop ? ~empty : ~full);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  assign head  = empty ? '0 : r_mem[r_rd_ptr];
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/hart_request_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hart_request_ctrl
// Purpose  : Per-hart issue eligibility and arbiter request generation.
// Revision : 1.0 - initial release
// ============================================================================
module hart_request_ctrl #(
  parameter int NUM_THREADS       = riscv_defines::NUM_THREADS,
  parameter int THREAD_ADDR_WIDTH = riscv_defines::THREAD_ADDR_WIDTH,
  parameter int PIPE_DEPTH        = 3,
  parameter int REDIRECT_CYCLES   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_THREADS-1:0]       hart_en_i,
  input  logic                         gnt_valid_i,
  input  logic [THREAD_ADDR_WIDTH-1:0] gnt_i,
  input  logic                         redirect_i,
  input  logic [THREAD_ADDR_WIDTH-1:0] redirect_hart_i,
  input  logic                         ld_issue_i,
  input  logic [THREAD_ADDR_WIDTH-1:0] ld_hart_i,
  input  logic                         data_rvalid_i,
  output logic [NUM_THREADS-1:0]       request_o,
  output logic [NUM_THREADS-1:0]       ld_pending_o,
  output logic [THREAD_ADDR_WIDTH-1:0] rvalid_hart_o,
  output logic                         err_o
);

  import riscv_defines::*;

  localparam int                        FIFO_CNT_W   = $clog2(NUM_THREADS + 1);
  localparam logic [HART_CNT_WIDTH-1:0] C_PIPE_INIT  = HART_CNT_WIDTH'(PIPE_DEPTH - 1);
  localparam logic [HART_CNT_WIDTH-1:0] C_REDIR_INIT = HART_CNT_WIDTH'(REDIRECT_CYCLES - 1);

  logic [THREAD_ADDR_WIDTH-1:0] w_head;
  logic                         w_fifo_full;
  logic                         w_fifo_empty;
  logic [FIFO_CNT_W-1:0]        w_fifo_count;
  logic                         w_rvalid_fire;
  logic                         w_overflow;
  logic                         w_underflow;
  logic                         r_err;

  hart_id_fifo #(
    .DEPTH (NUM_THREADS),
    .WIDTH (THREAD_ADDR_WIDTH)
  ) u_ld_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ld_issue_i),
    .pop   (data_rvalid_i),
    .din   (ld_hart_i),
    .head  (w_head),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  // Only a return that actually retires a queued load may release a hart.
  assign w_rvalid_fire = data_rvalid_i & (w_fifo_count != '0);
  assign w_overflow    = ld_issue_i & ~data_rvalid_i & w_fifo_full;
  assign w_underflow   = data_rvalid_i & ~ld_issue_i & w_fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst) r_err <= 1'b0;
    else      r_err <= r_err | w_overflow | w_underflow;
  end

  assign err_o         = r_err;
  assign rvalid_hart_o = w_head;

  for (genvar h = 0; h < NUM_THREADS; h++) begin : g_hart
    hart_state_e               r_state;
    logic [HART_CNT_WIDTH-1:0] r_cnt;
    logic                      w_en;
    logic                      w_grant;
    logic                      w_redirect;
    logic                      w_load;
    logic                      w_ld_return;

    assign w_en        = hart_en_i[h];
    assign w_grant     = gnt_valid_i & (gnt_i == THREAD_ADDR_WIDTH'(h));
    assign w_redirect  = redirect_i & (redirect_hart_i == THREAD_ADDR_WIDTH'(h));
    assign w_load      = ld_issue_i & (ld_hart_i == THREAD_ADDR_WIDTH'(h));
    assign w_ld_return = w_rvalid_fire & (w_head == THREAD_ADDR_WIDTH'(h));

    always_ff @(posedge clk) begin
      if (!rst) begin
        r_state <= HART_OFF;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          HART_OFF: begin
            if (w_en) r_state <= HART_READY;
          end
          HART_READY: begin
            if (!w_en) begin
              r_state <= HART_OFF;
            end else if (w_grant) begin
              r_state <= HART_ISSUED;
              r_cnt   <= C_PIPE_INIT;
            end
          end
          HART_ISSUED: begin
            if (!w_en) begin
              r_state <= HART_OFF;
            end else if (w_redirect) begin
              r_state <= HART_REDIRECT;
              r_cnt   <= C_REDIR_INIT;
            end else if (w_load) begin
              r_state <= HART_WAIT_LD;
            end else if (r_cnt == '0) begin
              r_state <= HART_READY;
            end else begin
              r_cnt <= r_cnt - HART_CNT_WIDTH'(1);
            end
          end
          HART_WAIT_LD: begin
            // A disabled hart still holds here until its load drains.
            if (w_ld_return) r_state <= w_en ? HART_READY : HART_OFF;
          end
          HART_REDIRECT: begin
            if (!w_en) begin
              r_state <= HART_OFF;
            end else if (r_cnt == '0) begin
              r_state <= HART_READY;
            end else begin
              r_cnt <= r_cnt - HART_CNT_WIDTH'(1);
            end
          end
          default: r_state <= HART_OFF;
        endcase
      end
    end

    assign request_o[h]    = (r_state == HART_READY);
    assign ld_pending_o[h] = (r_state == HART_WAIT_LD);
  end

endmodule
`default_nettype wire

// File: tb/tb_hart_request_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hart_request_ctrl
// Purpose  : Self-checking bench: vector table, directed corners, random run.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hart_request_ctrl;

  localparam int NT = 4;
  localparam int P  = 3;
  localparam int RC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] hart_en_i = '0;
  logic       gnt_valid_i = 1'b0;
  logic [1:0] gnt_i = '0;
  logic       redirect_i = 1'b0;
  logic [1:0] redirect_hart_i = '0;
  logic       ld_issue_i = 1'b0;
  logic [1:0] ld_hart_i = '0;
  logic       data_rvalid_i = 1'b0;
  logic [3:0] request_o;
  logic [3:0] ld_pending_o;
  logic [1:0] rvalid_hart_o;
  logic       err_o;

  hart_request_ctrl #(
    .NUM_THREADS       (NT),
    .THREAD_ADDR_WIDTH (2),
    .PIPE_DEPTH        (P),
    .REDIRECT_CYCLES   (RC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .hart_en_i       (hart_en_i),
    .gnt_valid_i     (gnt_valid_i),
    .gnt_i           (gnt_i),
    .redirect_i      (redirect_i),
    .redirect_hart_i (redirect_hart_i),
    .ld_issue_i      (ld_issue_i),
    .ld_hart_i       (ld_hart_i),
    .data_rvalid_i   (data_rvalid_i),
    .request_o       (request_o),
    .ld_pending_o    (ld_pending_o),
    .rvalid_hart_o   (rvalid_hart_o),
    .err_o           (err_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a hart is eligible once the edge count reaches its release point.
  int m_n = 0;
  bit m_on   [NT];
  bit m_wait [NT];
  bit m_iss  [NT];
  int m_rel  [NT];
  int m_q [$];
  bit m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_req();
    logic [3:0] r;
    for (int h = 0; h < NT; h++) r[h] = m_on[h] && !m_wait[h] && (m_n >= m_rel[h]);
    return r;
  endfunction

  function automatic logic [3:0] exp_pend();
    logic [3:0] r;
    for (int h = 0; h < NT; h++) r[h] = m_wait[h];
    return r;
  endfunction

  function automatic logic [1:0] exp_head();
    return (m_q.size() > 0) ? 2'(m_q[0]) : 2'd0;
  endfunction

  task automatic model_update();
    int  e;
    bit  pop_ok;
    int  owner;
    bit  rdy;
    bit  busy_iss;
    e = m_n + 1;
    if (!rst) begin
      for (int h = 0; h < NT; h++) begin
        m_on[h] = 0; m_wait[h] = 0; m_iss[h] = 0; m_rel[h] = 0;
      end
      m_q.delete();
      m_err = 0;
      m_n = e;
      return;
    end
    pop_ok = data_rvalid_i && (m_q.size() > 0);
    owner  = pop_ok ? m_q[0] : -1;
    for (int h = 0; h < NT; h++) begin
      rdy      = m_on[h] && !m_wait[h] && (m_n >= m_rel[h]);
      busy_iss = m_on[h] && !m_wait[h] && m_iss[h] && (m_n < m_rel[h]);
      if (!m_on[h]) begin
        if (hart_en_i[h]) begin m_on[h] = 1; m_rel[h] = 0; m_iss[h] = 0; end
      end else if (m_wait[h]) begin
        if (owner == h) begin m_wait[h] = 0; m_on[h] = hart_en_i[h]; m_rel[h] = 0; end
      end else if (!hart_en_i[h]) begin
        m_on[h] = 0; m_iss[h] = 0; m_rel[h] = 0;
      end else if (rdy) begin
        if (gnt_valid_i && gnt_i == 2'(h)) begin m_iss[h] = 1; m_rel[h] = e + P; end
      end else if (busy_iss) begin
        if (redirect_i && redirect_hart_i == 2'(h)) begin
          m_iss[h] = 0; m_rel[h] = e + RC;
        end else if (ld_issue_i && ld_hart_i == 2'(h)) begin
          m_iss[h] = 0; m_wait[h] = 1; m_rel[h] = 0;
        end
      end
    end
    if (ld_issue_i && data_rvalid_i) begin
      if (m_q.size() > 0) begin void'(m_q.pop_front()); m_q.push_back(int'(ld_hart_i)); end
    end else if (ld_issue_i) begin
      if (m_q.size() < NT) m_q.push_back(int'(ld_hart_i));
      else m_err = 1;
    end else if (data_rvalid_i) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      else m_err = 1;
    end
    m_n = e;
  endtask

  task automatic drive(input bit r, input logic [3:0] en, input bit gv, input logic [1:0] g,
                       input bit rd, input logic [1:0] rh, input bit ld, input logic [1:0] lh,
                       input bit rv);
    rst = r; hart_en_i = en; gnt_valid_i = gv; gnt_i = g; redirect_i = rd;
    redirect_hart_i = rh; ld_issue_i = ld; ld_hart_i = lh; data_rvalid_i = rv;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("model_request", 32'(request_o), 32'(exp_req()));
    check("model_ld_pending", 32'(ld_pending_o), 32'(exp_pend()));
    check("model_rvalid_hart", 32'(rvalid_hart_o), 32'(exp_head()));
    check("model_err", 32'(err_o), 32'(m_err));
  endtask

  task automatic idle(input logic [3:0] en);
    drive(1, en, 0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic do_reset();
    drive(0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  typedef struct {
    bit         r;
    logic [3:0] en;
    bit         gv;
    logic [1:0] g;
    bit         rd;
    logic [1:0] rh;
    bit         ld;
    logic [1:0] lh;
    bit         rv;
    logic [3:0] req;
    logic [3:0] pend;
    logic [1:0] rvh;
    bit         err;
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{0, 4'h0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 4'h0, 4'h0, 2'd0, 0};
    tbl[1]  = '{1, 4'h1, 0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 4'h1, 4'h0, 2'd0, 0};
    tbl[2]  = '{1, 4'hF, 1, 2'd0, 0, 2'd0, 0, 2'd0, 0, 4'hE, 4'h0, 2'd0, 0};
    tbl[3]  = '{1, 4'hF, 0, 2'd0, 0, 2'd0, 1, 2'd0, 0, 4'hE, 4'h1, 2'd0, 0};
    tbl[4]  = '{1, 4'hF, 1, 2'd1, 0, 2'd0, 0, 2'd0, 0, 4'hC, 4'h1, 2'd0, 0};
    tbl[5]  = '{1, 4'hF, 0, 2'd0, 1, 2'd1, 0, 2'd0, 0, 4'hC, 4'h1, 2'd0, 0};
    tbl[6]  = '{1, 4'hF, 0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 4'hC, 4'h1, 2'd0, 0};
    tbl[7]  = '{1, 4'hF, 0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 4'hE, 4'h1, 2'd0, 0};
    tbl[8]  = '{1, 4'hF, 0, 2'd0, 0, 2'd0, 0, 2'd0, 1, 4'hF, 4'h0, 2'd0, 0};
    tbl[9]  = '{1, 4'hF, 0, 2'd0, 0, 2'd0, 0, 2'd0, 1, 4'hF, 4'h0, 2'd0, 1};
    tbl[10] = '{1, 4'hF, 0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 4'hF, 4'h0, 2'd0, 1};

    #2;
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].r, tbl[i].en, tbl[i].gv, tbl[i].g, tbl[i].rd, tbl[i].rh,
            tbl[i].ld, tbl[i].lh, tbl[i].rv);
      step();
      check($sformatf("tbl%0d_request", i), 32'(request_o), 32'(tbl[i].req));
      check($sformatf("tbl%0d_ld_pending", i), 32'(ld_pending_o), 32'(tbl[i].pend));
      check($sformatf("tbl%0d_rvalid_hart", i), 32'(rvalid_hart_o), 32'(tbl[i].rvh));
      check($sformatf("tbl%0d_err", i), 32'(err_o), 32'(tbl[i].err));
    end

    // Grant timing: blocked for PIPE_DEPTH cycles.
    do_reset();
    idle(4'hF);
    drive(1, 4'hF, 1, 2'd2, 0, 0, 0, 0, 0); step();
    check("gnt2_blk0", 32'(request_o[2]), 32'd0);
    idle(4'hF); check("gnt2_blk1", 32'(request_o[2]), 32'd0);
    idle(4'hF); check("gnt2_blk2", 32'(request_o[2]), 32'd0);
    idle(4'hF); check("gnt2_rise", 32'(request_o[2]), 32'd1);

    // Load on hart 1 held until its rvalid seven cycles later.
    drive(1, 4'hF, 1, 2'd1, 0, 0, 0, 0, 0); step();
    drive(1, 4'hF, 0, 2'd0, 0, 0, 1, 2'd1, 0); step();
    for (int i = 0; i < 6; i++) begin
      idle(4'hF);
      check("ld1_pending", 32'(ld_pending_o[1]), 32'd1);
    end
    drive(1, 4'hF, 0, 2'd0, 0, 0, 0, 0, 1);
    #1 check("ld1_rvalid_hart", 32'(rvalid_hart_o), 32'd1);
    step();
    check("ld1_req_back", 32'(request_o[1]), 32'd1);
    check("ld1_pending_clr", 32'(ld_pending_o[1]), 32'd0);

    // FIFO ordering with a simultaneous push/pop.
    do_reset();
    idle(4'hF);
    drive(1, 4'hF, 0, 0, 0, 0, 1, 2'd3, 0); step();
    drive(1, 4'hF, 0, 0, 0, 0, 1, 2'd0, 0); step();
    drive(1, 4'hF, 0, 0, 0, 0, 1, 2'd2, 0); step();
    check("order_head3", 32'(rvalid_hart_o), 32'd3);
    drive(1, 4'hF, 0, 0, 0, 0, 1, 2'd1, 1); step();
    check("order_head0", 32'(rvalid_hart_o), 32'd0);
    drive(1, 4'hF, 0, 0, 0, 0, 0, 0, 1); step();
    check("order_head2", 32'(rvalid_hart_o), 32'd2);
    drive(1, 4'hF, 0, 0, 0, 0, 0, 0, 1); step();
    check("order_head1", 32'(rvalid_hart_o), 32'd1);
    drive(1, 4'hF, 0, 0, 0, 0, 0, 0, 1); step();
    check("order_drained_err", 32'(err_o), 32'd0);

    // Redirect on hart 0.
    do_reset();
    idle(4'h1);
    drive(1, 4'h1, 1, 2'd0, 0, 0, 0, 0, 0); step();
    drive(1, 4'h1, 0, 2'd0, 1, 2'd0, 0, 0, 0); step();
    check("redir_low0", 32'(request_o[0]), 32'd0);
    idle(4'h1); check("redir_low1", 32'(request_o[0]), 32'd0);
    idle(4'h1); check("redir_rise", 32'(request_o[0]), 32'd1);

    // Overflow is sticky until reset.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 4'h0, 0, 0, 0, 0, 1, 2'(i), 0); step();
      check($sformatf("ovf_push%0d_err", i), 32'(err_o), (i == 4) ? 32'd1 : 32'd0);
    end
    idle(4'h0); idle(4'h0);
    check("ovf_sticky", 32'(err_o), 32'd1);
    do_reset();
    check("ovf_reset_clr", 32'(err_o), 32'd0);

    // Randomised legal traffic against the model, with occasional resets.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [3:0] en;
      bit r, gv, rd, ld, rv;
      en = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
      r  = ($urandom_range(0, 149) != 0);
      gv = ($urandom_range(0, 9) < 7);
      rd = ($urandom_range(0, 4) == 0);
      ld = ($urandom_range(0, 3) == 0) && (m_q.size() < NT);
      rv = ($urandom_range(0, 9) < 3) && (m_q.size() > 0);
      drive(r, en, gv, 2'($urandom), rd, 2'($urandom), ld, 2'($urandom), rv);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
